// File: rtl/seq_nibble_adder.sv
// seq_nibble_adder: WIDTH-bit adder built from a single 4-bit carry-lookahead
// adder. One nibble is added per clock, least significant nibble first. The
// nibble carry is held in a register between cycles. A start/ready/done
// handshake faces the requester.
//
// Optional feature: define SIGNED_OVF_EN to add a registered signed-overflow
// output. This output is captured at the final nibble and held with cout.
//
// WIDTH must be a multiple of 4 and at least 4.
//
// state | meaning
// IDLE  | ready; waits for start and latches operands on acceptance
// RUN   | adds one nibble per edge, idx selects the nibble
// DONE  | one-cycle done pulse; the result is valid

module carry_look_ahead_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  logic [3:0] g, p;
  logic [3:0] c;

  // generate/propagate lookahead carries, no ripple chain
  always_comb begin
    g = a_i & b_i;
    p = a_i ^ b_i;
    c[0] = cin_i;
    c[1] = g[0] | (p[0] & cin_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);
    cout_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin_i);
    sum_o = p ^ c;
  end
endmodule

module seq_nibble_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SIGNED_OVF_EN
  ,
  output logic             overflow
`endif
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SIGNED_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [3:0] nib_a, nib_b, cla_sum;
  logic       cla_cout;

  // slice the current nibble out of the latched operands
  always_comb begin
    nib_a = a_q[4*int'(idx_q) +: 4];
    nib_b = b_q[4*int'(idx_q) +: 4];
  end

  carry_look_ahead_4bit u_cla (
    .a_i   (nib_a),
    .b_i   (nib_b),
    .cin_i (c_q),
    .sum_o (cla_sum),
    .cout_o(cla_cout)
  );

  // state and datapath registers, synchronous reset aborts any add in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SIGNED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SIGNED_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // next-state, nibble sequencing and handshake outputs
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SIGNED_OVF_EN
    ovf_d   = ovf_q;
`endif
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        sum_d[4*int'(idx_q) +: 4] = cla_sum;
        c_d = cla_cout;
        if (idx_q == LAST) begin
          cout_d  = cla_cout;
`ifdef SIGNED_OVF_EN
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (cla_sum[3] != a_q[WIDTH-1]);
`endif
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SIGNED_OVF_EN
  assign overflow = ovf_q;
`endif
endmodule

// File: tb/tb_seq_nibble_adder.sv
// Scoreboard bench for seq_nibble_adder. It uses one 16-bit instance and one
// 4-bit instance. The stimulus pushes hand-computed results, and per-instance
// monitors pop them whenever done is seen.
module tb_seq_nibble_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ready16, busy16, done16, cout16;
  logic [15:0] sum16;
  logic        start4 = 1'b0, cin4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        ready4, busy4, done4, cout4;
  logic [3:0]  sum4;
`ifdef SIGNED_OVF_EN
  logic        ovf16, ovf4;
`endif

  seq_nibble_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .ready(ready16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
`ifdef SIGNED_OVF_EN
    , .overflow(ovf16)
`endif
  );

  seq_nibble_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SIGNED_OVF_EN
    , .overflow(ovf4)
`endif
  );

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t q16[$];
  exp_t q4[$];
  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 16-bit result monitor
  initial forever begin
    exp_t e;
    @(posedge clk); #1;
    if (done16) begin
      if (q16.size() == 0) chk("spurious_done16", 32'd1, 32'd0);
      else begin
        e = q16.pop_front();
        chk("sum16", 32'(sum16), 32'(e.sum));
        chk("cout16", 32'(cout16), 32'(e.cout));
`ifdef SIGNED_OVF_EN
        chk("ovf16", 32'(ovf16), 32'(e.ovf));
`endif
      end
    end
  end

  // 4-bit result monitor
  initial forever begin
    exp_t e;
    @(posedge clk); #1;
    if (done4) begin
      if (q4.size() == 0) chk("spurious_done4", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        chk("sum4", 32'(sum4), 32'(e.sum));
        chk("cout4", 32'(cout4), 32'(e.cout));
`ifdef SIGNED_OVF_EN
        chk("ovf4", 32'(ovf4), 32'(e.ovf));
`endif
      end
    end
  end

  task automatic add16(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                       input logic [15:0] es, input logic ec, input logic eo, input bit hold);
    int n;
    int busy_n;
    exp_t e;
    n = 0;
    while (!ready16 && n < 20) begin @(posedge clk); #1; n++; end
    chk("ready16_before_start", 32'(ready16), 32'd1);
    e.sum = es; e.cout = ec; e.ovf = eo;
    q16.push_back(e);
    a16 = av; b16 = bv; cin16 = ci; start16 = 1'b1;
    @(posedge clk); #1;
    if (hold) begin a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1; end
    else start16 = 1'b0;
    n = 0; busy_n = 0;
    while (!done16 && n < 20) begin
      if (busy16) busy_n++;
      @(posedge clk); #1; n++;
    end
    chk("latency16", 32'(n), 32'd4);
    chk("busy_cycles16", 32'(busy_n), 32'd4);
    chk("ready16_in_done", 32'(ready16), 32'd0);
    start16 = 1'b0;
    @(posedge clk); #1;
    chk("ready16_after_done", 32'(ready16), 32'd1);
    chk("done16_one_cycle", 32'(done16), 32'd0);
  endtask

  task automatic add4(input logic [3:0] av, input logic [3:0] bv, input logic ci,
                      input logic [3:0] es, input logic ec, input logic eo);
    int n;
    exp_t e;
    e.sum = 16'(es); e.cout = ec; e.ovf = eo;
    q4.push_back(e);
    a4 = av; b4 = bv; cin4 = ci; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    chk("busy4_run", 32'(busy4), 32'd1);
    n = 0;
    while (!done4 && n < 10) begin @(posedge clk); #1; n++; end
    chk("latency4", 32'(n), 32'd1);
    @(posedge clk); #1;
    chk("ready4_after_done", 32'(ready4), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_done;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready16", 32'(ready16), 32'd1);
    chk("rst_busy16", 32'(busy16), 32'd0);
    chk("rst_done16", 32'(done16), 32'd0);
    chk("rst_sum16", 32'(sum16), 32'd0);
    chk("rst_cout16", 32'(cout16), 32'd0);
`ifdef SIGNED_OVF_EN
    chk("rst_ovf16", 32'(ovf16), 32'd0);
`endif
    chk("rst_ready4", 32'(ready4), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    add16(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    add16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    add16(16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0, 1'b0);
    add16(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1);
    add16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    add16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    add16(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);

    // abort on the second RUN cycle; the previous add left cout=1
    a16 = 16'h1357; b16 = 16'h2222; cin16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    @(posedge clk); #1;
    chk("busy16_before_abort", 32'(busy16), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready16", 32'(ready16), 32'd1);
    chk("abort_busy16", 32'(busy16), 32'd0);
    chk("abort_done16", 32'(done16), 32'd0);
    chk("abort_sum16", 32'(sum16), 32'd0);
    chk("abort_cout16", 32'(cout16), 32'd0);
    saw_done = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (done16) saw_done = 1'b1; end
    chk("abort_no_done16", 32'(saw_done), 32'd0);
    add16(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

    add4(4'd14, 4'd1, 1'b1, 4'd0, 1'b1, 1'b0);
    add4(4'd9, 4'd9, 1'b1, 4'd3, 1'b1, 1'b1);
    add4(4'd5, 4'd7, 1'b0, 4'd12, 1'b0, 1'b1);
    add4(4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("q16_drained", 32'(q16.size()), 32'd0);
    chk("q4_drained", 32'(q4.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
